// File: rtl/branch_pkg.sv
// Shared constants and types for the execute-stage branch resolution controller.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// Branch request, resolution, redirect and statistics signals between execute and its neighbours.
interface branch_ctrl_if #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 br_valid;
  logic                 br_ready;
  logic [2:0]           br_funct3;
  logic                 br_is_jump;
  logic [DWIDTH-1:0]    br_rs1;
  logic [DWIDTH-1:0]    br_rs2;
  logic [AWIDTH-1:0]    br_pc;
  logic [AWIDTH-1:0]    br_target;
  logic                 br_pred_taken;
  logic                 res_valid;
  logic                 res_taken;
  logic                 res_mispredict;
  logic                 flush;
  logic                 redir_valid;
  logic                 redir_ready;
  logic [AWIDTH-1:0]    redir_pc;
  logic [CNT_WIDTH-1:0] cnt_branch;
  logic [CNT_WIDTH-1:0] cnt_mispredict;

  modport master (
    output br_valid, br_funct3, br_is_jump, br_rs1, br_rs2, br_pc, br_target,
           br_pred_taken, redir_ready,
    input  br_ready, res_valid, res_taken, res_mispredict, flush, redir_valid,
           redir_pc, cnt_branch, cnt_mispredict
  );

  modport slave (
    input  br_valid, br_funct3, br_is_jump, br_rs1, br_rs2, br_pc, br_target,
           br_pred_taken, redir_ready,
    output br_ready, res_valid, res_taken, res_mispredict, flush, redir_valid,
           redir_pc, cnt_branch, cnt_mispredict
  );
endinterface

// File: rtl/branch_ctrl_comp.sv
// BRANCH_COMP: shared equality / less-than comparator with signed or unsigned ordering.
module branch_comp #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] i_a,
  input  logic [DWIDTH-1:0] i_b,
  input  logic              i_unsigned,
  output logic              o_eq,
  output logic              o_lt
);
  assign o_eq = (i_a == i_b);
  assign o_lt = i_unsigned ? (i_a < i_b) : ($signed(i_a) < $signed(i_b));
endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: evaluates one latched branch, flags mispredicts and
// holds a redirect to fetch until accepted.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  branch_ctrl_if.slave bus
);
  state_t               r_state, w_state_nxt;
  logic                 r_rdy_en;
  logic [2:0]           r_funct3;
  logic                 r_is_jump;
  logic [DWIDTH-1:0]    r_rs1, r_rs2;
  logic [AWIDTH-1:0]    r_pc, r_target, r_redir_pc;
  logic                 r_pred;
  logic [CNT_WIDTH-1:0] r_cnt_branch, r_cnt_mis;

  logic              w_eq, w_lt, w_taken, w_mispredict, w_accept, w_eval;
  logic [AWIDTH-1:0] w_next_pc;

  branch_comp #(.DWIDTH(DWIDTH)) u_comp (
    .i_a        (r_rs1),
    .i_b        (r_rs2),
    .i_unsigned (r_funct3[1]),
    .o_eq       (w_eq),
    .o_lt       (w_lt)
  );

  always_comb begin
    w_taken = 1'b0;
    if (r_is_jump) begin
      w_taken = 1'b1;
    end else begin
      case (r_funct3)
        BEQ:         w_taken = w_eq;
        BNE:         w_taken = !w_eq;
        BLT, BLTU:   w_taken = w_lt;
        BGE, BGEU:   w_taken = !w_lt;
        default:     w_taken = 1'b0;
      endcase
    end
  end

  assign w_next_pc    = w_taken ? r_target : r_pc + AWIDTH'(PC_INC);
  assign w_mispredict = w_taken ^ r_pred;
  assign w_eval       = (r_state == EVAL);
  // r_rdy_en keeps br_ready low until the first clock after reset release
  assign w_accept     = (r_state == IDLE) && r_rdy_en && bus.br_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_state_nxt = EVAL;
      EVAL:     w_state_nxt = w_mispredict ? REDIRECT : IDLE;
      REDIRECT: if (bus.redir_ready) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3     <= '0;
      r_is_jump    <= 1'b0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_pc         <= '0;
      r_target     <= '0;
      r_pred       <= 1'b0;
      r_redir_pc   <= '0;
      r_cnt_branch <= '0;
      r_cnt_mis    <= '0;
    end else begin
      if (w_accept) begin
        r_funct3  <= bus.br_funct3;
        r_is_jump <= bus.br_is_jump;
        r_rs1     <= bus.br_rs1;
        r_rs2     <= bus.br_rs2;
        r_pc      <= bus.br_pc;
        r_target  <= bus.br_target;
        r_pred    <= bus.br_pred_taken;
      end
      if (w_eval) begin
        r_cnt_branch <= r_cnt_branch + CNT_WIDTH'(1);
        if (w_mispredict) begin
          r_cnt_mis  <= r_cnt_mis + CNT_WIDTH'(1);
          r_redir_pc <= w_next_pc;
        end
      end
    end
  end

  assign bus.br_ready       = (r_state == IDLE) && r_rdy_en;
  assign bus.res_valid      = w_eval;
  assign bus.res_taken      = w_eval && w_taken;
  assign bus.res_mispredict = w_eval && w_mispredict;
  assign bus.flush          = w_eval && w_mispredict;
  assign bus.redir_valid    = (r_state == REDIRECT);
  assign bus.redir_pc       = r_redir_pc;
  assign bus.cnt_branch     = r_cnt_branch;
  assign bus.cnt_mispredict = r_cnt_mis;
endmodule
